// File: rtl/wb_trace_buffer.sv
// Writeback trace buffer: captures register-file writeback events into a FIFO
// and replays each one as a fixed-length LSB-first burst of OUT_W-bit words.
module wb_trace_buffer #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 8,
    parameter int OUT_W  = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wb_valid,
    input  logic [ADDR_W-1:0]          wb_rd,
    input  logic [DATA_W-1:0]          wb_data,
    input  logic                       filt_en,
    input  logic                       clear,
    output logic                       out_valid,
    output logic [OUT_W-1:0]           out_data,
    output logic                       out_last,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count,
    output logic                       overflow,
    output logic [7:0]                 drop_cnt
);

    localparam int REC_W   = ADDR_W + DATA_W;
    localparam int NWORDS  = (REC_W + OUT_W - 1) / OUT_W;
    localparam int SHIFT_W = NWORDS * OUT_W;
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = $clog2(DEPTH + 1);
    localparam int IDX_W   = (NWORDS > 1) ? $clog2(NWORDS) : 1;

    typedef enum logic {S_IDLE, S_SEND} state_t;

    state_t               state_q, state_d;
    logic [SHIFT_W-1:0]   shift_q, shift_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 overflow_q, overflow_d;
    logic [7:0]           drop_cnt_q, drop_cnt_d;

    logic [REC_W-1:0]     fifo_mem [DEPTH];
    logic [SHIFT_W-1:0]   head;
    logic                 qualified, handshake, last_word, push, pop, drop;

    assign qualified = wb_valid & ~clear & ~(filt_en & (wb_rd == '0));
    assign handshake = (state_q == S_SEND) & out_ready;
    assign last_word = (idx_q == IDX_W'(NWORDS - 1));
    // A pop needs an entry present before the edge, so an empty FIFO never bypasses.
    assign pop  = ~clear & (count_q != '0) & ((state_q == S_IDLE) | (handshake & last_word));
    assign push = qualified & ((count_q != CNT_W'(DEPTH)) | pop);
    assign drop = qualified & ~push;

    always_comb begin
        head = '0;
        head[REC_W-1:0] = fifo_mem[rd_ptr_q];
    end

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        idx_d      = idx_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        if (clear) begin
            state_d    = S_IDLE;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
            drop_cnt_d = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (pop) begin
                        shift_d = head;
                        idx_d   = '0;
                        state_d = S_SEND;
                    end
                end
                S_SEND: begin
                    if (handshake) begin
                        if (!last_word) begin
                            shift_d = shift_q >> OUT_W;
                            idx_d   = idx_q + IDX_W'(1);
                        end else if (pop) begin
                            shift_d = head;
                            idx_d   = '0;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
            if (drop) begin
                overflow_d = 1'b1;
                if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            shift_q    <= '0;
            idx_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            idx_q      <= idx_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Storage carries no reset; occupancy is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q] <= {wb_rd, wb_data};
    end

    assign out_valid  = (state_q == S_SEND);
    assign out_last   = out_valid & last_word;
    assign out_data   = out_valid ? shift_q[OUT_W-1:0] : '0;
    assign fifo_count = count_q;
    assign overflow   = overflow_q;
    assign drop_cnt   = drop_cnt_q;

endmodule
